// File: rtl/mc_cmd_arbiter.sv
// rtl/mc_cmd_arbiter.sv - two-port round-robin + refresh arbiter in front of command_fsm
module mc_cmd_arbiter #(
  parameter int ROW_W     = 14,
  parameter int COL_W     = 10,
  parameter int BANK_W    = 3,
  parameter int TREFI_CYC = 7800,
  parameter int REF_MAX   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_done,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ROW_W-1:0]  p0_row,
  input  logic [COL_W-1:0]  p0_col,
  input  logic [BANK_W-1:0] p0_bank,
  output logic              p0_gnt,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ROW_W-1:0]  p1_row,
  input  logic [COL_W-1:0]  p1_col,
  input  logic [BANK_W-1:0] p1_bank,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic              read_req,
  output logic              write_req,
  output logic              refresh_req,
  output logic [ROW_W-1:0]  row_addr,
  output logic [COL_W-1:0]  col_addr,
  output logic [BANK_W-1:0] bank_addr,
  input  logic              read_issued,
  input  logic              write_issued,
  input  logic              precharge_issued,
  input  logic              refresh_issued,
  output logic [3:0]        ref_pending,
  output logic              ref_urgent
);

  localparam int TMR_W = (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_CLOSE = 3'd2,
    S_REF   = 3'd3,
    S_REFW  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic             wrap;
  logic             prech_q, refi_q;
  logic             prech_fall, refi_fall;
  logic             rr, gport;
  logic             any_req, win, we_win;
  logic             gnt0_d, gnt1_d, done0_d, done1_d;
  logic             rd_d, wr_d, rf_d, latch, rr_d, dec;
  logic [3:0]       pend_nxt;

  assign wrap       = init_done && (tmr == TMR_W'(TREFI_CYC - 1));
  assign prech_fall = prech_q & ~precharge_issued;
  assign refi_fall  = refi_q & ~refresh_issued;
  assign any_req    = p0_req | p1_req;
  // rr port wins when it is requesting, otherwise the other port
  assign win        = rr ? p1_req : ~p0_req;
  assign we_win     = win ? p1_we : p0_we;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic; refresh always beats host traffic in idle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (init_done) begin
          if (ref_pending != 4'd0) state_nxt = S_REF;
          else if (any_req)        state_nxt = S_CMD;
        end
      end
      S_CMD:   if (read_issued || write_issued) state_nxt = S_CLOSE;
      S_CLOSE: if (prech_fall)                  state_nxt = S_IDLE;
      S_REF:   if (refresh_issued)              state_nxt = S_REFW;
      S_REFW:  if (refi_fall)                   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // next values of the registered outputs and bookkeeping strobes
  always_comb begin
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    rf_d    = 1'b0;
    latch   = 1'b0;
    rr_d    = rr;
    dec     = 1'b0;
    case (state)
      S_IDLE: begin
        if (init_done) begin
          if (ref_pending != 4'd0) begin
            rf_d = 1'b1;
          end else if (any_req) begin
            latch  = 1'b1;
            gnt0_d = ~win;
            gnt1_d = win;
            rd_d   = ~we_win;
            wr_d   = we_win;
          end
        end
      end
      S_CMD: begin
        if (!(read_issued || write_issued)) begin
          rd_d = read_req;
          wr_d = write_req;
        end
      end
      S_CLOSE: begin
        if (prech_fall) begin
          done0_d = ~gport;
          done1_d = gport;
          rr_d    = ~gport;
        end
      end
      S_REF:   rf_d = ~refresh_issued;
      S_REFW:  dec  = refi_fall;
      default: ;
    endcase
  end

  // postponed-refresh counter: wrap and completion in the same cycle cancel out
  always_comb begin
    pend_nxt = ref_pending;
    if (wrap && !dec) begin
      if (ref_pending != 4'(REF_MAX)) pend_nxt = ref_pending + 4'd1;
    end else if (dec && !wrap && ref_pending != 4'd0) begin
      pend_nxt = ref_pending - 4'd1;
    end
  end

  // registered outputs, refresh timer, edge-detect copies and address latch
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr         <= '0;
      prech_q     <= 1'b0;
      refi_q      <= 1'b0;
      rr          <= 1'b0;
      gport       <= 1'b0;
      p0_gnt      <= 1'b0;
      p1_gnt      <= 1'b0;
      p0_done     <= 1'b0;
      p1_done     <= 1'b0;
      read_req    <= 1'b0;
      write_req   <= 1'b0;
      refresh_req <= 1'b0;
      row_addr    <= '0;
      col_addr    <= '0;
      bank_addr   <= '0;
      ref_pending <= 4'd0;
      ref_urgent  <= 1'b0;
    end else begin
      tmr         <= (init_done && !wrap) ? tmr + TMR_W'(1) : '0;
      prech_q     <= precharge_issued;
      refi_q      <= refresh_issued;
      rr          <= rr_d;
      p0_gnt      <= gnt0_d;
      p1_gnt      <= gnt1_d;
      p0_done     <= done0_d;
      p1_done     <= done1_d;
      read_req    <= rd_d;
      write_req   <= wr_d;
      refresh_req <= rf_d;
      ref_pending <= pend_nxt;
      ref_urgent  <= (pend_nxt == 4'(REF_MAX));
      if (latch) begin
        gport     <= win;
        row_addr  <= win ? p1_row : p0_row;
        col_addr  <= win ? p1_col : p0_col;
        bank_addr <= win ? p1_bank : p0_bank;
      end
    end
  end

endmodule

// File: tb/tb_mc_cmd_arbiter.sv
// tb/tb_mc_cmd_arbiter.sv - self-checking bench for mc_cmd_arbiter
module tb_mc_cmd_arbiter;

  localparam int ROW_W = 14;
  localparam int COL_W = 10;
  localparam int BANK_W = 3;
  localparam int TREFI = 16;
  localparam int RMAX = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_done = 1'b0;
  logic p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [ROW_W-1:0] p0_row = '0, p1_row = '0;
  logic [COL_W-1:0] p0_col = '0, p1_col = '0;
  logic [BANK_W-1:0] p0_bank = '0, p1_bank = '0;
  logic read_issued = 1'b0, write_issued = 1'b0;
  logic precharge_issued = 1'b0, refresh_issued = 1'b0;
  logic p0_gnt, p0_done, p1_gnt, p1_done;
  logic read_req, write_req, refresh_req, ref_urgent;
  logic [ROW_W-1:0] row_addr;
  logic [COL_W-1:0] col_addr;
  logic [BANK_W-1:0] bank_addr;
  logic [3:0] ref_pending;

  always #5 clk = ~clk;

  mc_cmd_arbiter #(.ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W),
                   .TREFI_CYC(TREFI), .REF_MAX(RMAX)) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .p0_req(p0_req), .p0_we(p0_we), .p0_row(p0_row), .p0_col(p0_col), .p0_bank(p0_bank),
    .p0_gnt(p0_gnt), .p0_done(p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_row(p1_row), .p1_col(p1_col), .p1_bank(p1_bank),
    .p1_gnt(p1_gnt), .p1_done(p1_done),
    .read_req(read_req), .write_req(write_req), .refresh_req(refresh_req),
    .row_addr(row_addr), .col_addr(col_addr), .bank_addr(bank_addr),
    .read_issued(read_issued), .write_issued(write_issued),
    .precharge_issued(precharge_issued), .refresh_issued(refresh_issued),
    .ref_pending(ref_pending), .ref_urgent(ref_urgent)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural model: who owns command_fsm, and how far along that job is
  int m_tick, m_pend, m_owner, m_stage, m_rr;
  bit m_lp, m_lr;
  logic e_g0, e_g1, e_d0, e_d1, e_rd, e_wr, e_rf;
  logic [ROW_W-1:0] e_row;
  logic [COL_W-1:0] e_col;
  logic [BANK_W-1:0] e_bank;

  task automatic model_step();
    bit wrap, fin;
    int pick;
    if (reset) begin
      m_tick = 0; m_pend = 0; m_owner = -1; m_stage = 0; m_rr = 0; m_lp = 0; m_lr = 0;
      e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0; e_rd = 0; e_wr = 0; e_rf = 0;
      e_row = '0; e_col = '0; e_bank = '0;
      return;
    end
    e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0;
    fin = 0;
    wrap = init_done && (m_tick == TREFI - 1);
    m_tick = (init_done && !wrap) ? m_tick + 1 : 0;
    if (m_owner == -1) begin
      if (init_done) begin
        if (m_pend > 0) begin
          m_owner = 2; m_stage = 0; e_rf = 1;
        end else if (p0_req || p1_req) begin
          if (m_rr == 0) pick = p0_req ? 0 : 1;
          else           pick = p1_req ? 1 : 0;
          m_owner = pick; m_stage = 0;
          if (pick == 0) begin
            e_g0 = 1; e_row = p0_row; e_col = p0_col; e_bank = p0_bank; e_wr = p0_we;
          end else begin
            e_g1 = 1; e_row = p1_row; e_col = p1_col; e_bank = p1_bank; e_wr = p1_we;
          end
          e_rd = !e_wr;
        end
      end
    end else if (m_owner == 2) begin
      if (m_stage == 0) begin
        if (refresh_issued) begin e_rf = 0; m_stage = 1; end
      end else if (m_lr && !refresh_issued) begin
        fin = 1; m_owner = -1;
      end
    end else begin
      if (m_stage == 0) begin
        if (read_issued || write_issued) begin e_rd = 0; e_wr = 0; m_stage = 1; end
      end else if (m_lp && !precharge_issued) begin
        if (m_owner == 0) e_d0 = 1; else e_d1 = 1;
        m_rr = 1 - m_owner;
        m_owner = -1;
      end
    end
    if (wrap && !fin) m_pend = (m_pend < RMAX) ? m_pend + 1 : RMAX;
    else if (fin && !wrap) m_pend = m_pend - 1;
    m_lp = precharge_issued;
    m_lr = refresh_issued;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("p0_gnt", p0_gnt, e_g0);
    chk("p1_gnt", p1_gnt, e_g1);
    chk("p0_done", p0_done, e_d0);
    chk("p1_done", p1_done, e_d1);
    chk("read_req", read_req, e_rd);
    chk("write_req", write_req, e_wr);
    chk("refresh_req", refresh_req, e_rf);
    chk("row_addr", row_addr, e_row);
    chk("col_addr", col_addr, e_col);
    chk("bank_addr", bank_addr, e_bank);
    chk("ref_pending", ref_pending, m_pend);
    chk("ref_urgent", ref_urgent, m_pend == RMAX);
  end

  // event log: 0/1 grant, 10/11 done, 20 refresh_req rising
  int ev[$];
  int g_count = 0, d0_count = 0, d1_count = 0;
  bit prev_rf = 0;
  initial forever begin
    @(negedge clk);
    if (p0_gnt) begin ev.push_back(0); g_count++; end
    if (p1_gnt) begin ev.push_back(1); g_count++; end
    if (p0_done) begin ev.push_back(10); d0_count++; end
    if (p1_done) begin ev.push_back(11); d1_count++; end
    if (refresh_req && !prev_rf) ev.push_back(20);
    prev_rf = refresh_req;
  end

  // host side: drop request once granted unless streaming continuously
  bit cont0 = 0, cont1 = 0;
  initial forever begin
    @(posedge clk); #1;
    if (p0_gnt && !cont0) p0_req = 0;
    if (p1_gnt && !cont1) p1_req = 0;
  end

  // command_fsm stand-in
  bit stall = 0;
  initial forever begin
    @(posedge clk); #1;
    if (!stall && (read_req || write_req)) begin
      if (write_req) write_issued = 1; else read_issued = 1;
      repeat (2) begin @(posedge clk); #1; end
      read_issued = 0; write_issued = 0;
      @(posedge clk); #1;
      precharge_issued = 1;
      repeat (2) begin @(posedge clk); #1; end
      precharge_issued = 0;
    end else if (!stall && refresh_req) begin
      refresh_issued = 1;
      repeat (4) begin @(posedge clk); #1; end
      refresh_issued = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gnt(output int port, input int budget);
    port = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (p0_gnt) begin port = 0; break; end
      if (p1_gnt) begin port = 1; break; end
    end
    if (port < 0) begin
      n_checks++; n_fail++;
      $display("FAIL wait_gnt: no grant within %0d cycles", budget);
    end
  endtask

  // 0: refresh_req  1: ref_pending != 0  2: fully quiet  3: any done
  task automatic wait_cond(input int which, input int budget, output int cycles);
    bit hit;
    hit = 0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      case (which)
        0: hit = refresh_req;
        1: hit = (ref_pending != 0);
        2: hit = (ref_pending == 0) && !refresh_req && !read_req && !write_req &&
                 !read_issued && !write_issued && !precharge_issued && !refresh_issued;
        default: hit = p0_done || p1_done;
      endcase
      if (hit) break;
    end
    if (!hit) begin
      n_checks++; n_fail++;
      $display("FAIL wait_cond %0d: timeout after %0d cycles", which, budget);
    end
  endtask

  initial begin
    int port, cyc_n, base, nref;
    int got[4];

    // A: reset, then requests with init_done low
    p0_req = 1; p0_we = 0; p0_row = 14'h12; p0_col = 10'h5; p0_bank = 3'd2;
    cyc(3);
    reset = 0;
    chk("A rst read_req", read_req, 0);
    chk("A rst ref_pending", ref_pending, 0);
    chk("A rst row_addr", row_addr, 0);
    cyc(100);
    chk("A no gnt", g_count, 0);
    chk("A read_req", read_req, 0);
    chk("A ref_pending", ref_pending, 0);

    // B: first refresh after TREFI cycles
    p0_req = 0;
    init_done = 1;
    wait_cond(0, 40, cyc_n);
    chk("B refresh latency", cyc_n, 17);
    chk("B ref_pending", ref_pending, 1);
    chk("B ref_urgent", ref_urgent, 0);
    wait_cond(2, 30, cyc_n);
    chk("B drained", ref_pending, 0);

    // C: both ports from reset, p0 first, then p1 write
    reset = 1;
    p0_we = 0; p0_row = 14'h12; p0_col = 10'h5; p0_bank = 3'd2;
    p1_we = 1; p1_row = 14'h33; p1_col = 10'h1A; p1_bank = 3'd5;
    p0_req = 1; p1_req = 1;
    cyc(2);
    base = d0_count;
    reset = 0;
    wait_gnt(port, 10);
    chk("C first port", port, 0);
    chk("C read_req", read_req, 1);
    chk("C write_req", write_req, 0);
    chk("C row", row_addr, 32'h12);
    chk("C col", col_addr, 32'h5);
    chk("C bank", bank_addr, 2);
    wait_gnt(port, 60);
    chk("C second port", port, 1);
    chk("C p1 write_req", write_req, 1);
    chk("C p1 row", row_addr, 32'h33);
    chk("C p0 done before p1", d0_count - base, 1);
    wait_cond(3, 40, cyc_n);

    // D: both ports continuous -> alternating grants
    cont0 = 1; cont1 = 1; p0_req = 1; p1_req = 1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(port, 80);
      got[i] = port;
    end
    cont0 = 0; cont1 = 0; p0_req = 0; p1_req = 0;
    chk("D grant0", got[0], 0);
    chk("D grant1", got[1], 1);
    chk("D grant2", got[2], 0);
    chk("D grant3", got[3], 1);
    wait_cond(2, 80, cyc_n);

    // E: wraps while p0 sits in close; saturation; done before refresh before p1
    stall = 1;
    p0_req = 1;
    wait_gnt(port, 10);
    chk("E port", port, 0);
    read_issued = 1;
    cyc(1);
    read_issued = 0;
    precharge_issued = 1;
    p1_req = 1;
    wait_cond(1, 40, cyc_n);
    cyc(170);
    chk("E saturated", ref_pending, RMAX);
    chk("E urgent", ref_urgent, 1);
    ev.delete();
    precharge_issued = 0;
    stall = 0;
    wait_gnt(port, 400);
    chk("E p1 after refreshes", port, 1);
    chk("E first event done0", ev.size() > 0 ? ev[0] : -1, 10);
    chk("E second event refresh", ev.size() > 1 ? ev[1] : -1, 20);
    nref = 0;
    foreach (ev[i]) if (ev[i] == 20) nref++;
    chk("E refreshes before p1", nref >= RMAX, 1);
    wait_cond(3, 60, cyc_n);

    // F: reset while in S_CMD aborts, then a fresh grant works
    wait_cond(2, 80, cyc_n);
    stall = 1;
    p0_req = 1;
    wait_gnt(port, 10);
    chk("F port", port, 0);
    cyc(1);
    chk("F read_req held", read_req, 1);
    base = d0_count;
    reset = 1;
    cyc(1);
    chk("F rst p0_gnt", p0_gnt, 0);
    chk("F rst p0_done", p0_done, 0);
    chk("F rst read_req", read_req, 0);
    chk("F rst write_req", write_req, 0);
    chk("F rst refresh_req", refresh_req, 0);
    chk("F rst row", row_addr, 0);
    chk("F rst col", col_addr, 0);
    chk("F rst bank", bank_addr, 0);
    chk("F rst pending", ref_pending, 0);
    chk("F rst urgent", ref_urgent, 0);
    reset = 0;
    cyc(10);
    chk("F no done after abort", d0_count - base, 0);
    base = d1_count;
    stall = 0;
    p1_req = 1;
    wait_gnt(port, 10);
    chk("F fresh port", port, 1);
    chk("F fresh write_req", write_req, 1);
    wait_cond(3, 40, cyc_n);
    cyc(1);
    chk("F p1 done", d1_count - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
